axi_rd_arbiter: RTL and testbench

//  Shares the single AXI3 read-address/read-data channel pair between the IF-stage

---
 rtl/axi_rd_arbiter_pkg.sv | 22 ++
 rtl/axi_rd_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: default read ids, AR register and grant encodings.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] DEF_ID_INST = 4'd0;
    localparam logic [3:0] DEF_ID_DATA = 4'd1;

    typedef enum logic {
        ArEmpty,
        ArFull
    } ar_state_e;

    typedef enum logic {
        GrantInst,
        GrantData
    } grant_e;

    // Reads and writes collide when they touch the same 32-bit word.
    function automatic logic same_word(logic [31:0] a, logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Arbitrates the inst and data sram-like read ports onto one AXI3 AR/R channel pair,
// with one outstanding read per id and a registered AR holding stage.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [3:0] ID_INST = DEF_ID_INST,
    parameter logic [3:0] ID_DATA = DEF_ID_DATA
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    input  logic        wr_busy,
    input  logic [31:0] wr_addr,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    ar_state_e   ar_state_q, ar_state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        busy_inst_q, busy_inst_d;
    logic        busy_data_q, busy_data_d;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;

    logic can_grant, raw_hazard, inst_elig, data_elig;
    logic grant_inst, grant_data, grant_any;
    logic r_fire, ret_inst, ret_data;

    // R is always accepted once out of reset; unmatched beats are simply dropped.
    assign rready = aresetn;

    always_comb begin
        can_grant  = aresetn && ((ar_state_q == ArEmpty) || arready);
        raw_hazard = wr_busy && same_word(wr_addr, data_addr);
        inst_elig  = inst_req && !busy_inst_q;
        data_elig  = data_req && !busy_data_q && !raw_hazard;
        grant_inst = can_grant && inst_elig && (!data_elig || (last_grant_q == GrantData));
        grant_data = can_grant && data_elig && !grant_inst;
        grant_any  = grant_inst || grant_data;

        r_fire   = rvalid && rready;
        ret_inst = r_fire && (rid == ID_INST) && busy_inst_q;
        ret_data = r_fire && (rid == ID_DATA) && busy_data_q;
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = ret_inst;
    assign data_data_ok = ret_data;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // Next state: a return and a new grant for the same id in one cycle leaves busy set.
    always_comb begin
        ar_state_d   = ar_state_q;
        last_grant_d = last_grant_q;
        busy_inst_d  = (busy_inst_q && !ret_inst) || grant_inst;
        busy_data_d  = (busy_data_q && !ret_data) || grant_data;

        if (grant_inst) begin
            last_grant_d = GrantInst;
        end else if (grant_data) begin
            last_grant_d = GrantData;
        end

        unique case (ar_state_q)
            ArEmpty: begin
                if (grant_any) begin
                    ar_state_d = ArFull;
                end
            end
            ArFull: begin
                if (arready && !grant_any) begin
                    ar_state_d = ArEmpty;
                end
            end
            default: ar_state_d = ArEmpty;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q   <= ArEmpty;
            last_grant_q <= GrantData;
            busy_inst_q  <= 1'b0;
            busy_data_q  <= 1'b0;
        end else begin
            ar_state_q   <= ar_state_d;
            last_grant_q <= last_grant_d;
            busy_inst_q  <= busy_inst_d;
            busy_data_q  <= busy_data_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid_q   <= 4'd0;
            araddr_q <= 32'd0;
            arsize_q <= 3'd0;
        end else if (grant_inst) begin
            arid_q   <= ID_INST;
            araddr_q <= inst_addr;
            arsize_q <= {1'b0, inst_size};
        end else if (grant_data) begin
            arid_q   <= ID_DATA;
            araddr_q <= data_addr;
            arsize_q <= {1'b0, data_size};
        end
    end

    assign arvalid = (ar_state_q == ArFull);
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: a rule-level model predicts grants and
// returns, and monitors compare every AR handshake and every returned read against queues.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, wr_busy, arready, rvalid;
    logic [31:0] inst_addr, data_addr, wr_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        arvalid, rready;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;

    axi_rd_arbiter dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .wr_busy      (wr_busy),
        .wr_addr      (wr_addr),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;

    int checks = 0;
    int errors = 0;

    ar_t         ar_exp[$];
    logic [31:0] inst_exp[$];
    logic [31:0] data_exp[$];

    // Reference model: outstanding read per side, AR slot occupancy, side granted last.
    bit m_busy_inst, m_busy_data, m_ar_full, m_last_data;

    // AXI slave: remembers accepted reads and returns them after a random delay.
    bit slv_pend[2];
    int slv_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy_inst = 0;
        m_busy_data = 0;
        m_ar_full   = 0;
        m_last_data = 1;
        ar_exp.delete();
        inst_exp.delete();
        data_exp.delete();
    endtask

    // Evaluated at the falling edge, with this cycle's inputs settled.
    task automatic model_eval();
        bit can, ie, de, gi, gd, ri, rd, hazard;
        can    = !m_ar_full || arready;
        hazard = wr_busy && (wr_addr[31:2] == data_addr[31:2]);
        ie     = inst_req && !m_busy_inst;
        de     = data_req && !m_busy_data && !hazard;
        // Alternate when both want the channel; otherwise whoever asks.
        gi     = can && ie && (!de || m_last_data);
        gd     = can && de && !gi;
        ri     = rvalid && (rid == 4'd0) && m_busy_inst;
        rd     = rvalid && (rid == 4'd1) && m_busy_data;

        chk("arvalid", {31'd0, arvalid}, {31'd0, m_ar_full});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, gi});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, gd});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, ri});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, rd});
        chk("rready", {31'd0, rready}, 32'd1);

        if (ri) inst_exp.push_back(rdata);
        if (rd) data_exp.push_back(rdata);
        if (gi) ar_exp.push_back('{id: 4'd0, addr: inst_addr, size: {1'b0, inst_size}});
        if (gd) ar_exp.push_back('{id: 4'd1, addr: data_addr, size: {1'b0, data_size}});

        m_busy_inst = (m_busy_inst && !ri) || gi;
        m_busy_data = (m_busy_data && !rd) || gd;
        m_ar_full   = gi || gd || (m_ar_full && !arready);
        if (gi) m_last_data = 0;
        if (gd) m_last_data = 1;

        if (arvalid && arready && arid < 4'd2) begin
            slv_pend[arid[0]] = 1;
            slv_cnt[arid[0]]  = $urandom_range(0, 4);
        end
    endtask

    task automatic drive_random(input bit reqs_on);
        int pick;
        inst_req  = reqs_on && ($urandom_range(0, 9) < 7);
        inst_addr = $urandom;
        inst_size = 2'($urandom_range(0, 2));
        data_req  = reqs_on && ($urandom_range(0, 9) < 7);
        data_addr = $urandom;
        data_size = 2'($urandom_range(0, 2));
        wr_busy   = ($urandom_range(0, 9) < 3);
        wr_addr   = $urandom_range(0, 1) ? {data_addr[31:2], 2'($urandom)} : $urandom;
        arready   = !reqs_on || ($urandom_range(0, 3) != 0);

        rvalid = 0;
        rid    = 4'd0;
        rdata  = $urandom;
        pick   = -1;
        for (int i = 0; i < 2; i++) begin
            if (slv_cnt[i] > 0) slv_cnt[i]--;
            else if (slv_pend[i] && (pick < 0 || $urandom_range(0, 1) == 1)) pick = i;
        end
        if (pick >= 0 && $urandom_range(0, 3) != 0) begin
            rvalid         = 1;
            rid            = 4'(pick);
            slv_pend[pick] = 0;
        end else if ($urandom_range(0, 15) == 0) begin
            rvalid = 1;
            rid    = 4'($urandom_range(0, 3));
        end
    endtask

    task automatic run_cycles(input int n, input bit reqs_on);
        for (int c = 0; c < n; c++) begin
            @(posedge aclk);
            #1;
            drive_random(reqs_on);
            @(negedge aclk);
            model_eval();
        end
    endtask

    // AR monitor: every handshake must match the oldest predicted grant.
    always @(negedge aclk) begin
        #2;
        if (aresetn && arvalid && arready) begin
            if (ar_exp.size() == 0) begin
                chk("ar_unexpected", {28'd0, arid}, 32'hffff_ffff);
            end else begin
                ar_t e;
                e = ar_exp.pop_front();
                chk("arid", {28'd0, arid}, {28'd0, e.id});
                chk("araddr", araddr, e.addr);
                chk("arsize", {29'd0, arsize}, {29'd0, e.size});
            end
        end
    end

    // R monitor: returned data must match the beat the model expected to be delivered.
    always @(negedge aclk) begin
        #2;
        if (inst_data_ok) begin
            if (inst_exp.size() == 0) chk("inst_rdata_unexpected", inst_rdata, 32'hdead_beef);
            else chk("inst_rdata", inst_rdata, inst_exp.pop_front());
        end
        if (data_data_ok) begin
            if (data_exp.size() == 0) chk("data_rdata_unexpected", data_rdata, 32'hdead_beef);
            else chk("data_rdata", data_rdata, data_exp.pop_front());
        end
    end

    initial begin
        slv_pend = '{0, 0};
        slv_cnt  = '{0, 0};
        model_reset();
        aresetn   = 0;
        inst_req  = 1;
        inst_addr = 32'h1c00_0000;
        inst_size = 2'd2;
        data_req  = 1;
        data_addr = 32'h0000_1000;
        data_size = 2'd2;
        wr_busy   = 0;
        wr_addr   = 32'd0;
        arready   = 1;
        rvalid    = 1;
        rid       = 4'd0;
        rdata     = 32'h0280_0404;

        // Requests and an R beat held during reset must produce nothing.
        #2;
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_arid", {28'd0, arid}, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arsize", {29'd0, arsize}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_held_arvalid", {31'd0, arvalid}, 32'd0);
        inst_req = 0;
        data_req = 0;
        rvalid   = 0;
        aresetn  = 1;
        @(negedge aclk);
        model_eval();

        run_cycles(3000, 1);

        // Park a read in the AR slot under backpressure, then reset on top of it.
        @(posedge aclk);
        #1;
        inst_req  = 1;
        inst_addr = 32'h1c00_0040;
        data_req  = 0;
        wr_busy   = 0;
        arready   = 0;
        rvalid    = 0;
        @(negedge aclk);
        model_eval();
        @(posedge aclk);
        #1;
        inst_req = 0;
        @(negedge aclk);
        model_eval();
        #3;
        aresetn = 0;
        rvalid  = 1;
        rid     = 4'd0;
        #1;
        chk("midrst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("midrst_rready", {31'd0, rready}, 32'd0);
        chk("midrst_ok", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        chk("midrst_held_arvalid", {31'd0, arvalid}, 32'd0);
        rvalid  = 0;
        aresetn = 1;
        @(negedge aclk);
        model_eval();

        run_cycles(1000, 1);
        run_cycles(30, 0);

        chk("ar_exp_drained", ar_exp.size(), 32'd0);
        chk("arvalid_idle", {31'd0, arvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
